calc_direct_issue_ctl: RTL and testbench
========================================

# calc_direct_issue_ctl

Issue controller and phase sequencer for the direct-lighting shade pipelines. It generates the one-hot three-phase strobes `v0`/`v1`/`v2` that time-multiplex the shared float units, and admits one ray per three-cycle slot. Admission is credit-based against the downstream result FIFO, so the non-stallable shade pipeline can never overflow it. It also regenerates the pipeline's output-valid (FIFO write enable) by delaying each issue by the fixed pipeline latency.

## Interface
Parameters:
- `LATENCY`, 105: cycles from the issue edge to the result being present at the FIFO input; must be ≥ 1.
- `FIFO_DEPTH`, 35: result FIFO entries; initial credit count.
- `CNT_W`, 6: width of the credit and in-flight counters; must hold `FIFO_DEPTH`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `v0`, `v1`, `v2`  out  1 each  one-hot phase strobes.
- `us_valid`  in  1  upstream ray present.
- `us_stall`  out  1  upstream must hold its data.
- `issue`  out  1  ray accepted into the pipeline this cycle.
- `fifo_we`  out  1  pipeline result valid; write it to the FIFO.
- `fifo_re`  in  1  FIFO entry popped by the arbiter.
- `credits`  out  `CNT_W`  free FIFO slots not yet reserved.
- `in_flight`  out  `CNT_W`  rays issued but not yet written.
- `busy`  out  1  `in_flight != 0`.
- `err`  out  1  sticky protocol error.

## Operation
- **Phase ring.** Exactly one of `v0`/`v1`/`v2` is high in every cycle. The ring advances `v0` → `v1` → `v2` → `v0` on each clock edge and runs unconditionally; stalls never freeze it.
- **Issue rule.** `issue = us_valid & v0 & (credits != 0)`.
- **Stall rule.** `us_stall = us_valid & ~issue`. `us_stall` is never asserted while `us_valid` is low.
- **Credit counter.**
  - −1 on `issue`.
  - +1 on `fifo_re`.
  - Unchanged when both occur, or when neither occurs.
  - There is no same-cycle bypass: a pop while `credits == 0` enables issue only from the next `v0`.
- **In-flight counter.**
  - +1 on `issue`.
  - −1 on `fifo_we`.
  - Unchanged when both occur.
- **Delay line.** A `LATENCY`-bit shift register, shifted every cycle, carries `issue` through to `fifo_we`. Because issue happens only on `v0`, `fifo_we` pulses are at least 3 cycles apart.
- **Error conditions** (`err` set; cleared only by reset):
  - `fifo_re` while `credits == FIFO_DEPTH` with no same-cycle issue (pop from an empty FIFO).
  - A credit increment that would exceed `FIFO_DEPTH`.
  - `fifo_we` while `in_flight == 0`.
  - When `err` is set, counters saturate instead of wrapping.
- **Invariant:** `credits + in_flight + FIFO occupancy == FIFO_DEPTH` at every edge.
- **Throughput.** Full rate of one ray per 3 cycles requires `FIFO_DEPTH ≥ ceil(LATENCY/3) + 1`. Smaller depths throttle issue but remain correct.

## Timing
- **Reset values** (while `rst` is low, asynchronous):
  - `v0`=1, `v1`=0, `v2`=0.
  - `credits`=`FIFO_DEPTH`, `in_flight`=0.
  - Delay line all 0, so `fifo_we`=0.
  - `busy`=0, `err`=0.
  - `issue`=0 and `us_stall`=0 until `us_valid` is sampled.
- **After reset.** On the first edge after `rst` deasserts, `v1` goes high; `v0` returns every 3rd cycle.
- **Combinational outputs.** `issue` and `us_stall` are combinational from `us_valid` and registered state, in the same cycle.
- **`fifo_we` latency.** An issue in cycle t produces `fifo_we` high in exactly cycle t+`LATENCY`.
- **Registered outputs.** `credits`, `in_flight`, `busy` and `err` are registered and reflect events one edge later.
- **Mid-flight reset.** Reset asserted while rays are in flight discards them: no `fifo_we` is produced for them after reset.

## Test plan
Run with `LATENCY`=9 and `FIFO_DEPTH`=4 unless noted.
- **Phase ring.** Release reset, hold `us_valid`=0 for 12 cycles → `v0`,`v1`,`v2` cycle 1-0-0, 0-1-0, 0-0-1 repeating; `credits`=4; `fifo_we`, `err` and `busy` stay 0.
- **Single issue.** Raise `us_valid` during a `v1` cycle → `us_stall`=1 for 2 cycles, `issue`=1 on the next `v0`. `fifo_we`=1 exactly 9 cycles after that issue, `credits` is 3, and `in_flight` goes 1 → 0.
- **Credit exhaustion.** Hold `us_valid`=1 with `fifo_re`=0 → exactly 4 issues on consecutive `v0` cycles, then `credits`=0 and `us_stall`=1 indefinitely. Pulse `fifo_re` once → exactly one more issue, on the first `v0` after the pop edge.
- **Simultaneous events.** Pulse `fifo_re` in the same cycle as an issue with `credits`=2 → `credits` remains 2.
- **Mid-flight reset.** Issue 2 rays, then assert `rst` for 1 cycle 4 cycles later → all outputs take their reset values immediately, and no `fifo_we` pulse follows.
- **Protocol error.** Pulse `fifo_re` with `credits`=4 and no issue → `err`=1 next cycle and `credits` stays at 4. `err` holds through later valid traffic until reset.

Source files
------------

// File: rtl/calc_direct_issue_ctl_if.sv
// Issue-controller bundle: upstream handshake, FIFO push/pop strobes, phase strobes and status.
interface calc_direct_issue_ctl_if #(
  parameter int unsigned CNT_W = 6
);
  logic             v0;
  logic             v1;
  logic             v2;
  logic             us_valid;
  logic             us_stall;
  logic             issue;
  logic             fifo_we;
  logic             fifo_re;
  logic [CNT_W-1:0] credits;
  logic [CNT_W-1:0] in_flight;
  logic             busy;
  logic             err;

  // Controller side
  modport master (
    input  us_valid, fifo_re,
    output v0, v1, v2, us_stall, issue, fifo_we, credits, in_flight, busy, err
  );

  // Environment side: upstream source and FIFO arbiter
  modport slave (
    output us_valid, fifo_re,
    input  v0, v1, v2, us_stall, issue, fifo_we, credits, in_flight, busy, err
  );
endinterface

// File: rtl/calc_direct_issue_ctl.sv
// Phase sequencer and credit-based issue controller for the direct-lighting shade pipelines.
// One ray may enter per three-cycle slot (on v0), only while a result FIFO slot is unreserved.
// LATENCY must be >= 1 and CNT_W must be wide enough to hold FIFO_DEPTH.
module calc_direct_issue_ctl #(
  parameter int unsigned LATENCY    = 105,
  parameter int unsigned FIFO_DEPTH = 35,
  parameter int unsigned CNT_W      = 6
) (
  input logic                     clk,
  input logic                     rst,
  calc_direct_issue_ctl_if.master bus
);

  localparam logic [CNT_W-1:0] Depth  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  typedef enum logic [2:0] {
    StV0 = 3'b001,
    StV1 = 3'b010,
    StV2 = 3'b100
  } phase_e;

  phase_e             phase_q, phase_d;
  logic [CNT_W-1:0]   credits_q, credits_d;
  logic [CNT_W-1:0]   in_flight_q, in_flight_d;
  logic [LATENCY-1:0] dly_q, dly_d;
  logic               err_q, err_d;

  logic issue;
  logic fifo_we;
  logic credit_inc, credit_dec;
  logic flight_inc, flight_dec;

  assign issue   = bus.us_valid & (phase_q == StV0) & (credits_q != '0);
  assign fifo_we = dly_q[LATENCY-1];

  // Simultaneous issue and pop cancel, as do simultaneous issue and write-back.
  assign credit_inc = bus.fifo_re & ~issue;
  assign credit_dec = issue & ~bus.fifo_re;
  assign flight_inc = issue & ~fifo_we;
  assign flight_dec = fifo_we & ~issue;

  // Phase ring state register; free-running, never frozen by stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= StV0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase ring next state: v0 -> v1 -> v2 -> v0
  always_comb begin
    phase_d = StV0;
    unique case (phase_q)
      StV0:    phase_d = StV1;
      StV1:    phase_d = StV2;
      StV2:    phase_d = StV0;
      default: phase_d = StV0;
    endcase
  end

  // Counter, delay-line and error next state; counters saturate rather than wrap
  always_comb begin
    credits_d   = credits_q;
    in_flight_d = in_flight_q;
    dly_d       = dly_q << 1;
    dly_d[0]    = issue;
    err_d       = err_q;

    if (credit_inc) begin
      if (credits_q < Depth) credits_d = credits_q + One;
    end else if (credit_dec) begin
      if (credits_q != '0) credits_d = credits_q - One;
    end

    if (flight_inc) begin
      if (in_flight_q != CntMax) in_flight_d = in_flight_q + One;
    end else if (flight_dec) begin
      if (in_flight_q != '0) in_flight_d = in_flight_q - One;
    end

    // Pop of an empty FIFO (credit overflow) or a write-back nobody issued
    if (credit_inc && (credits_q >= Depth)) err_d = 1'b1;
    if (fifo_we && (in_flight_q == '0))     err_d = 1'b1;
  end

  // Counter, delay-line and sticky-error registers; reset drops any rays in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q   <= Depth;
      in_flight_q <= '0;
      dly_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      credits_q   <= credits_d;
      in_flight_q <= in_flight_d;
      dly_q       <= dly_d;
      err_q       <= err_d;
    end
  end

  assign bus.v0        = (phase_q == StV0);
  assign bus.v1        = (phase_q == StV1);
  assign bus.v2        = (phase_q == StV2);
  assign bus.issue     = issue;
  assign bus.us_stall  = bus.us_valid & ~issue;
  assign bus.fifo_we   = fifo_we;
  assign bus.credits   = credits_q;
  assign bus.in_flight = in_flight_q;
  assign bus.busy      = (in_flight_q != '0);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_calc_direct_issue_ctl.sv
// Bench for calc_direct_issue_ctl: directed scenarios plus randomized traffic, checked every
// cycle against a slot/credit/write-schedule model, with literal expectations at key points.
module tb_calc_direct_issue_ctl;
  localparam int Lat   = 9;
  localparam int Depth = 4;
  localparam int CntW  = 6;

  logic clk = 1'b0;
  logic rst;

  calc_direct_issue_ctl_if #(.CNT_W(CntW)) bus ();

  calc_direct_issue_ctl #(
    .LATENCY   (Lat),
    .FIFO_DEPTH(Depth),
    .CNT_W     (CntW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: slot position, free credits, FIFO occupancy, error flag, due cycles of pending writes
  int m_ph;
  int m_cred;
  int m_occ;
  int m_now;
  bit m_err;
  int we_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ph   = 0;
    m_cred = Depth;
    m_occ  = 0;
    m_now  = 0;
    m_err  = 1'b0;
    we_q.delete();
  endfunction

  // Per-cycle comparison against the model, then advance the model across the coming edge
  initial begin
    bit e_issue;
    bit e_we;
    int e_inf;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst) model_reset();
      e_issue = bus.us_valid && (m_ph == 0) && (m_cred != 0);
      e_we    = (we_q.size() > 0) && (we_q[0] == m_now);
      e_inf   = we_q.size();
      chk("v0",        32'(bus.v0),        32'(m_ph == 0));
      chk("v1",        32'(bus.v1),        32'(m_ph == 1));
      chk("v2",        32'(bus.v2),        32'(m_ph == 2));
      chk("issue",     32'(bus.issue),     32'(e_issue));
      chk("us_stall",  32'(bus.us_stall),  32'(bus.us_valid && !e_issue));
      chk("fifo_we",   32'(bus.fifo_we),   32'(e_we));
      chk("credits",   32'(bus.credits),   32'(m_cred));
      chk("in_flight", 32'(bus.in_flight), 32'(e_inf));
      chk("busy",      32'(bus.busy),      32'(e_inf != 0));
      chk("err",       32'(bus.err),       32'(m_err));
      if (rst) begin
        if (bus.fifo_re && (m_cred == Depth) && !e_issue) m_err = 1'b1;
        if (e_we && (e_inf == 0)) m_err = 1'b1;
        m_cred = m_cred - int'(e_issue) + int'(bus.fifo_re);
        if (m_cred > Depth) m_cred = Depth;
        if (e_issue) we_q.push_back(m_now + Lat);
        if (e_we) void'(we_q.pop_front());
        m_occ = m_occ + int'(e_we) - int'(bus.fifo_re);
        if (m_occ < 0) m_occ = 0;
        m_ph = (m_ph + 1) % 3;
        m_now++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    tick();
    while ((m_ph != p) && (n < 5)) begin
      tick();
      n++;
    end
    chk("wait_phase", 32'(m_ph), 32'(p));
  endtask

  // Pop every buffered result and let in-flight rays land; called at 1 unit after an edge
  task automatic drain();
    int n;
    n = 0;
    while (((m_occ > 0) || (we_q.size() > 0)) && (n < 200)) begin
      bus.fifo_re = (m_occ > 0);
      tick();
      n++;
    end
    bus.fifo_re = 1'b0;
    chk("drain_done", 32'(n < 200), 32'd1);
  endtask

  task automatic issue_two();
    int cnt;
    int n;
    cnt = 0;
    n   = 0;
    bus.us_valid = 1'b1;
    while ((cnt < 2) && (n < 20)) begin
      #2;
      cnt += int'(bus.issue);
      tick();
      n++;
    end
    bus.us_valid = 1'b0;
    chk("issue_two", 32'(cnt), 32'd2);
  endtask

  initial begin
    int cnt;
    int lat;
    int pct;
    bit seen;
    rst          = 1'b1;
    bus.us_valid = 1'b0;
    bus.fifo_re  = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("rst_v0",      32'(bus.v0),        32'd1);
    chk("rst_credits", 32'(bus.credits),   32'd4);
    chk("rst_inflt",   32'(bus.in_flight), 32'd0);
    chk("rst_err",     32'(bus.err),       32'd0);

    // Idle phase ring: four v0 slots in twelve cycles
    cnt = 0;
    repeat (12) begin
      tick();
      #2;
      cnt += int'(bus.v0);
      chk("ring_onehot", 32'(bus.v0 + bus.v1 + bus.v2), 32'd1);
    end
    chk("ring_v0_count", 32'(cnt), 32'd4);

    // Single issue: raised on v1, stalls two cycles, result arrives Lat cycles after issue
    wait_phase(1);
    bus.us_valid = 1'b1;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      if (bus.issue) begin
        seen = 1'b1;
        break;
      end
      cnt += int'(bus.us_stall);
      tick();
    end
    chk("single_issue_seen", 32'(seen), 32'd1);
    chk("single_stall_cycles", 32'(cnt), 32'd2);
    tick();
    bus.us_valid = 1'b0;
    #2;
    chk("single_credits", 32'(bus.credits), 32'd3);
    chk("single_inflt",   32'(bus.in_flight), 32'd1);
    lat = 1;
    while (!bus.fifo_we && (lat < 20)) begin
      tick();
      #2;
      lat++;
    end
    chk("single_we_latency", 32'(lat), 32'(Lat));
    tick();
    #2;
    chk("single_inflt_after", 32'(bus.in_flight), 32'd0);

    // Credit exhaustion: free the one used slot, then hold valid with no pops
    tick();
    drain();
    bus.us_valid = 1'b1;
    cnt = 0;
    repeat (30) begin
      #2;
      cnt += int'(bus.issue);
      tick();
    end
    chk("exhaust_issues", 32'(cnt), 32'd4);
    #2;
    chk("exhaust_credits", 32'(bus.credits), 32'd0);
    chk("exhaust_stall", 32'(bus.us_stall), 32'd1);
    tick();
    bus.fifo_re = 1'b1;
    tick();
    bus.fifo_re = 1'b0;
    cnt = 0;
    repeat (15) begin
      #2;
      cnt += int'(bus.issue);
      tick();
    end
    chk("exhaust_one_more", 32'(cnt), 32'd1);
    bus.us_valid = 1'b0;
    drain();

    // Simultaneous issue and pop with two credits left
    issue_two();
    cnt = 0;
    while ((we_q.size() > 0) && (cnt < 30)) begin
      tick();
      cnt++;
    end
    wait_phase(0);
    bus.us_valid = 1'b1;
    bus.fifo_re  = 1'b1;
    #2;
    chk("simul_issue", 32'(bus.issue), 32'd1);
    chk("simul_credits_before", 32'(bus.credits), 32'd2);
    tick();
    bus.us_valid = 1'b0;
    bus.fifo_re  = 1'b0;
    #2;
    chk("simul_credits_after", 32'(bus.credits), 32'd2);
    tick();
    drain();

    // Mid-flight reset discards in-flight rays
    issue_two();
    repeat (3) tick();
    #1 rst = 1'b0;
    #1;
    chk("mrst_v0",      32'(bus.v0),        32'd1);
    chk("mrst_v1",      32'(bus.v1),        32'd0);
    chk("mrst_credits", 32'(bus.credits),   32'd4);
    chk("mrst_inflt",   32'(bus.in_flight), 32'd0);
    chk("mrst_busy",    32'(bus.busy),      32'd0);
    tick();
    rst = 1'b1;
    cnt = 0;
    repeat (15) begin
      #2;
      cnt += int'(bus.fifo_we);
      tick();
    end
    chk("mrst_no_we", 32'(cnt), 32'd0);

    // Randomized traffic with varying pop pressure
    for (int b = 0; b < 12; b++) begin
      pct = int'($urandom_range(0, 100));
      repeat (50) begin
        bus.us_valid = ($urandom_range(0, 3) != 0);
        bus.fifo_re  = (m_occ > 0) && (int'($urandom_range(0, 99)) < pct);
        tick();
      end
    end
    bus.us_valid = 1'b0;
    drain();

    // Protocol error: pop with all credits free, then sticky through traffic
    bus.fifo_re = 1'b1;
    tick();
    bus.fifo_re = 1'b0;
    #2;
    chk("perr_err", 32'(bus.err), 32'd1);
    chk("perr_credits", 32'(bus.credits), 32'd4);
    tick();
    repeat (60) begin
      bus.us_valid = ($urandom_range(0, 1) != 0);
      bus.fifo_re  = (m_occ > 0) && ($urandom_range(0, 1) != 0);
      tick();
    end
    bus.us_valid = 1'b0;
    bus.fifo_re  = 1'b0;
    #2;
    chk("perr_sticky", 32'(bus.err), 32'd1);
    tick();
    #1 rst = 1'b0;
    #1;
    chk("perr_cleared", 32'(bus.err), 32'd0);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
